// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate VGA raster counters with registered, zero-skew sync/active/frame-start.
// Define VGA_TIMING_FRAMECNT_EN to enable the oFrameCount completed-frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 640,
  parameter int H_FP    = 16,
  parameter int H_PW    = 96,
  parameter int H_BP    = 48,
  parameter int HEIGHT  = 480,
  parameter int V_FP    = 10,
  parameter int V_PW    = 2,
  parameter int V_BP    = 33
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oPixTick,
  output logic [9:0]  oCountH,
  output logic [9:0]  oCountV,
  output logic        oHS,
  output logic        oVS,
  output logic        oActive,
  output logic        oFrameStart,
  output logic [15:0] oFrameCount
);
  localparam int H_TOTAL = WIDTH + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_PW + V_BP;
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_timing_gen: H/V totals must be <= 1024 and CLK_DIV >= 1");
  end
  logic [PW-1:0] pre;
  logic          tick, h_wrap, v_wrap;
  logic [9:0]    h_nxt, v_nxt;
  always_comb begin
    tick   = pre == PW'(CLK_DIV - 1);
    h_wrap = tick && oCountH == 10'(H_TOTAL - 1);
    v_wrap = h_wrap && oCountV == 10'(V_TOTAL - 1);
    h_nxt  = h_wrap ? 10'd0 : oCountH + 10'(tick);
    v_nxt  = v_wrap ? 10'd0 : oCountV + 10'(h_wrap);
  end
  // Flags are decoded from the next counts so they land on the same edge as the counters.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      pre         <= '0;
      oCountH     <= '0;
      oCountV     <= '0;
      oHS         <= 1'b1;
      oVS         <= 1'b1;
      oActive     <= 1'b1;
      oPixTick    <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + PW'(1);
      oCountH     <= h_nxt;
      oCountV     <= v_nxt;
      oHS         <= !(h_nxt >= 10'(WIDTH + H_FP) && h_nxt <= 10'(WIDTH + H_FP + H_PW - 1));
      oVS         <= !(v_nxt >= 10'(HEIGHT + V_FP) && v_nxt <= 10'(HEIGHT + V_FP + V_PW - 1));
      oActive     <= h_nxt < 10'(WIDTH) && v_nxt < 10'(HEIGHT);
      oPixTick    <= tick;
      oFrameStart <= v_wrap;
    end
  end
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_cnt;
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + 16'(v_wrap);
  end
  assign oFrameCount = frame_cnt;
`else
  assign oFrameCount = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench on a shrunk raster (15x10, div 4 and div 1) against a cycle-index model.
module tb_vga_timing_gen;
  localparam int HT = 15;
  localparam int VT = 10;
  localparam int FRAME = 4 * HT * VT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick, hs, vs, act, fs, tick1, hs1, vs1, act1, fs1;
  logic [9:0] cnt_h, cnt_v, cnt_h1, cnt_v1;
  logic [15:0] fcnt, fcnt1;
  logic [15:0] fc_base = 16'h0000;
  int tests = 0, fails = 0, k = 0;
  int agg = 0, n_act = 0, n_hs = 0, n_vs = 0, n_fs = 0, first_fs = -1;
  always #5 clk = ~clk;
  vga_timing_gen #(.CLK_DIV(4), .WIDTH(8), .H_FP(2), .H_PW(3), .H_BP(2),
                   .HEIGHT(6), .V_FP(1), .V_PW(2), .V_BP(1)) dut (
    .iClk(clk), .iRst(rst_n), .oPixTick(tick), .oCountH(cnt_h), .oCountV(cnt_v),
    .oHS(hs), .oVS(vs), .oActive(act), .oFrameStart(fs), .oFrameCount(fcnt));
  vga_timing_gen #(.CLK_DIV(1), .WIDTH(8), .H_FP(2), .H_PW(3), .H_BP(2),
                   .HEIGHT(6), .V_FP(1), .V_PW(2), .V_BP(1)) dut1 (
    .iClk(clk), .iRst(rst_n), .oPixTick(tick1), .oCountH(cnt_h1), .oCountV(cnt_v1),
    .oHS(hs1), .oVS(vs1), .oActive(act1), .oFrameStart(fs1), .oFrameCount(fcnt1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Expected outputs follow from the number of edges k since reset release.
  task automatic step();
    int p, h, v, h1, v1;
    logic tk;
    @(negedge clk);
    k++;
    p  = k / 4;
    h  = p % HT;
    v  = (p / HT) % VT;
    tk = k % 4 == 0;
    h1 = k % HT;
    v1 = (k / HT) % VT;
    check($sformatf("h k=%0d", k), 32'(cnt_h), 32'(h));
    check($sformatf("v k=%0d", k), 32'(cnt_v), 32'(v));
    check($sformatf("tick k=%0d", k), 32'(tick), 32'(tk));
    check($sformatf("hs k=%0d", k), 32'(hs), 32'(!(h >= 10 && h <= 12)));
    check($sformatf("vs k=%0d", k), 32'(vs), 32'(!(v >= 7 && v <= 8)));
    check($sformatf("act k=%0d", k), 32'(act), 32'(h < 8 && v < 6));
    check($sformatf("fs k=%0d", k), 32'(fs), 32'(tk && h == 0 && v == 0));
    check($sformatf("h1 k=%0d", k), 32'(cnt_h1), 32'(h1));
    check($sformatf("v1 k=%0d", k), 32'(cnt_v1), 32'(v1));
    check($sformatf("tick1 k=%0d", k), 32'(tick1), 32'd1);
    check($sformatf("hs1 k=%0d", k), 32'(hs1), 32'(!(h1 >= 10 && h1 <= 12)));
    check($sformatf("vs1 k=%0d", k), 32'(vs1), 32'(!(v1 >= 7 && v1 <= 8)));
    check($sformatf("act1 k=%0d", k), 32'(act1), 32'(h1 < 8 && v1 < 6));
    check($sformatf("fs1 k=%0d", k), 32'(fs1), 32'(k % (HT * VT) == 0));
`ifdef VGA_TIMING_FRAMECNT_EN
    check($sformatf("fc k=%0d", k), 32'(fcnt), 32'(16'(fc_base + 16'(k / FRAME))));
    check($sformatf("fc1 k=%0d", k), 32'(fcnt1), 32'(16'(k / (HT * VT))));
`else
    check($sformatf("fc k=%0d", k), 32'(fcnt), 32'd0);
    check($sformatf("fc1 k=%0d", k), 32'(fcnt1), 32'd0);
`endif
    if (agg != 0) begin
      if (tick && act) n_act++;
      if (tick && !hs) n_hs++;
      if (tick && !vs) n_vs++;
      if (fs) begin
        n_fs++;
        if (first_fs < 0) first_fs = k;
      end
    end
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, " h"}, 32'(cnt_h), 32'd0);
    check({tag, " v"}, 32'(cnt_v), 32'd0);
    check({tag, " hs"}, 32'(hs), 32'd1);
    check({tag, " vs"}, 32'(vs), 32'd1);
    check({tag, " act"}, 32'(act), 32'd1);
    check({tag, " tick"}, 32'(tick), 32'd0);
    check({tag, " fs"}, 32'(fs), 32'd0);
    check({tag, " fc"}, 32'(fcnt), 32'd0);
    check({tag, " h1"}, 32'(cnt_h1), 32'd0);
    check({tag, " tick1"}, 32'(tick1), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    k = 0;
    agg = 1;
    repeat (FRAME) step();
    agg = 0;
    check("frame act ticks", 32'(n_act), 32'd48);
    check("frame hs-low ticks", 32'(n_hs), 32'd30);
    check("frame vs-low ticks", 32'(n_vs), 32'd30);
    check("frame fs count", 32'(n_fs), 32'd1);
    check("first fs edge", 32'(first_fs), 32'(FRAME));
    repeat (2 * FRAME) step();
`ifdef VGA_TIMING_FRAMECNT_EN
    check("fc after 3 frames", 32'(fcnt), 32'd3);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    fc_base = 16'hFFFC;
`else
    check("fc after 3 frames", 32'(fcnt), 32'd0);
`endif
    repeat (FRAME) step();
    check("fc after wrap frame", 32'(fcnt), 32'd0);
    for (int i = 0; i < 2 * FRAME && !((k / 4) % HT == 11 && (k / 4 / HT) % VT == 4 && k % 4 == 1); i++) step();
    check("pre-reset h", 32'(cnt_h), 32'd11);
    check("pre-reset v", 32'(cnt_v), 32'd4);
    check("pre-reset hs", 32'(hs), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async rst");
    repeat (2) @(posedge clk);
    #1 check_reset_vals("held rst");
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    fc_base = 16'h0000;
    repeat (FRAME + 100) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
